// File: rtl/wb_sram_pkg.sv
// wb_sram_pkg: shared definitions for the Wishbone SRAM responder.
//   state_e    - FSM state encoding (IDLE / WAIT / ACK)
//   CNT_W      - wait-state counter width
//   SEL_B0..3  - byte-lane select masks, big-endian (B0 = bits 31:24)
//   ZERO_WORD  - all-zero data word
package wb_sram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_e;

    localparam int unsigned CNT_W = 4;

    localparam logic [3:0] SEL_B0 = 4'b1000;
    localparam logic [3:0] SEL_B1 = 4'b0100;
    localparam logic [3:0] SEL_B2 = 4'b0010;
    localparam logic [3:0] SEL_B3 = 4'b0001;

    localparam logic [31:0] ZERO_WORD = '0;

endpackage

// File: rtl/wb_sram_array.sv
// wb_sram_array: word-organised single-port RAM with per-byte write enables.
//   clk_i   - clock; writes commit on the rising edge
//   we_i    - write enable
//   be_i    - byte enables, big-endian (be_i[3] -> bits 31:24)
//   idx_i   - word index (registered by the caller)
//   wdat_i  - write data
//   rdat_o  - combinational read of mem[idx_i]
// Contents are not reset.
module wb_sram_array
    import wb_sram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [3:0]            be_i,
    input  logic [ADDR_WIDTH-1:0] idx_i,
    input  logic [31:0]           wdat_i,
    output logic [31:0]           rdat_o
);

    logic [31:0] mem_q [2**ADDR_WIDTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            if ((be_i & SEL_B0) != '0) mem_q[idx_i][31:24] <= wdat_i[31:24];
            if ((be_i & SEL_B1) != '0) mem_q[idx_i][23:16] <= wdat_i[23:16];
            if ((be_i & SEL_B2) != '0) mem_q[idx_i][15:8]  <= wdat_i[15:8];
            if ((be_i & SEL_B3) != '0) mem_q[idx_i][7:0]   <= wdat_i[7:0];
        end
    end

    assign rdat_o = mem_q[idx_i];

endmodule

// File: rtl/wb_sram_slave.sv
// wb_sram_slave: Wishbone-classic SRAM target with configurable wait states.
//   clk, rst (sync, active-high)
//   wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i[31:0], wb_sel_i[3:0], wb_dat_i[31:0]
//   wb_dat_o[31:0] - read data in the ack cycle, zero otherwise
//   wb_ack_o       - one-cycle normal completion
//   wb_err_o       - one-cycle error completion
// Build option WB_SRAM_ERR_EN: requests with nonzero address bits above the
// memory range complete with wb_err_o and never write. Without it those bits
// are ignored (memory aliases) and wb_err_o is tied 0.
module wb_sram_slave
    import wb_sram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [31:0] wb_adr_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o
);

    localparam logic [CNT_W-1:0] CNT_LOAD =
        (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q,   cnt_d;
    logic                  we_q,    we_d;
    logic [ADDR_WIDTH-1:0] idx_q,   idx_d;
    logic [3:0]            sel_q,   sel_d;
    logic [31:0]           dat_q,   dat_d;
    logic                  err_q,   err_d;

    logic                  adr_err;
    logic                  resp;
    logic                  mem_we;
    logic [31:0]           rdat;
    logic                  unused_adr;

`ifdef WB_SRAM_ERR_EN
    assign adr_err    = |wb_adr_i[31:ADDR_WIDTH+2];
    assign unused_adr = ^wb_adr_i[1:0];
`else
    assign adr_err    = 1'b0;
    assign unused_adr = ^{wb_adr_i[31:ADDR_WIDTH+2], wb_adr_i[1:0]};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            idx_q   <= '0;
            sel_q   <= '0;
            dat_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            idx_q   <= idx_d;
            sel_q   <= sel_d;
            dat_q   <= dat_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        idx_d   = idx_q;
        sel_d   = sel_q;
        dat_d   = dat_q;
        err_d   = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (wb_cyc_i && wb_stb_i) begin
                    we_d  = wb_we_i;
                    idx_d = wb_adr_i[ADDR_WIDTH+1:2];
                    sel_d = wb_sel_i;
                    dat_d = wb_dat_i;
                    err_d = adr_err;
                    if (WAIT_CYCLES > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_LOAD;
                    end else begin
                        state_d = ST_ACK;
                    end
                end
            end
            ST_WAIT: begin
                // Dropping cyc abandons the request before anything commits.
                if (!wb_cyc_i) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = ST_ACK;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign resp = (state_q == ST_ACK);
    // rst gates the commit so a write whose ack edge meets reset is dropped.
    assign mem_we = resp && we_q && !err_q && !rst;

    wb_sram_array #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_array (
        .clk_i  (clk),
        .we_i   (mem_we),
        .be_i   (sel_q),
        .idx_i  (idx_q),
        .wdat_i (dat_q),
        .rdat_o (rdat)
    );

    assign wb_ack_o = resp && !err_q;
`ifdef WB_SRAM_ERR_EN
    assign wb_err_o = resp && err_q;
`else
    assign wb_err_o = 1'b0;
`endif
    assign wb_dat_o = wb_ack_o ? rdat : ZERO_WORD;

endmodule
